// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types, data width and character-length decode
package spi_pkg;
    localparam int SPI_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} rx_state_e;
    // char_len 3'b000 encodes a full 8-bit character
    function automatic logic [3:0] char_bits(input logic [2:0] char_len);
        return (char_len == 3'd0) ? 4'd8 : {1'b0, char_len};
    endfunction
endpackage

// File: rtl/dff.sv
// dff: W-bit rising-edge register with async active-low reset to RESET_VALUE
// Ports: clk, rst_n, d -> q
module dff #(
    parameter int             W           = 1,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= RESET_VALUE;
        else        q <= d;
endmodule

// File: rtl/miso_rx.sv
// miso_rx: SPI master receive path; samples MISO on sample_en into a 1-8 bit
// character and hands it to a holding register with valid/overrun flags.
// Ports: pclk/presetn; lsb, char_len config; transfer_start/abort control;
// sample_en + miso_pad_i serial input; rx_read ack; rx_data/rx_valid/
// rx_overrun holding register; busy while SHIFT or LOAD.
module miso_rx
    import spi_pkg::*;
#(
    parameter int                DATA_W     = SPI_DATA_W,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              lsb,
    input  logic [2:0]        char_len,
    input  logic              transfer_start,
    input  logic              transfer_abort,
    input  logic              sample_en,
    input  logic              miso_pad_i,
    input  logic              rx_read,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_overrun,
    output logic              busy
);
    logic [1:0]        state_q;
    rx_state_e         state, state_d;
    logic [2:0]        cnt, cnt_d, last_idx, idx;
    logic [DATA_W-1:0] shreg, shreg_d, data_d;
    logic              valid_d, ovr_d, last;

    assign state    = rx_state_e'(state_q);
    assign last_idx = 3'(char_bits(char_len) - 4'd1);
    assign last     = cnt == last_idx;
    assign idx      = lsb ? cnt : last_idx - cnt;
    assign busy     = state != IDLE;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shreg_d = shreg;
        data_d  = rx_data;
        valid_d = rx_read ? 1'b0 : rx_valid;
        ovr_d   = rx_read ? 1'b0 : rx_overrun;
        if (transfer_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: if (transfer_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
                SHIFT: if (sample_en) begin
                    shreg_d[idx] = miso_pad_i;
                    state_d      = last ? LOAD : SHIFT;
                    cnt_d        = last ? cnt : cnt + 3'd1;
                end
                LOAD: begin
                    // a coincident rx_read loses to the load
                    data_d  = shreg;
                    valid_d = 1'b1;
                    ovr_d   = rx_overrun | (rx_valid & ~rx_read);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    dff #(.W(2),      .RESET_VALUE(IDLE))       u_state (.clk(pclk), .rst_n(presetn), .d(state_d), .q(state_q));
    dff #(.W(3),      .RESET_VALUE(3'd0))       u_cnt   (.clk(pclk), .rst_n(presetn), .d(cnt_d),   .q(cnt));
    dff #(.W(DATA_W), .RESET_VALUE(RESET_DATA)) u_shreg (.clk(pclk), .rst_n(presetn), .d(shreg_d), .q(shreg));
    dff #(.W(DATA_W), .RESET_VALUE(RESET_DATA)) u_data  (.clk(pclk), .rst_n(presetn), .d(data_d),  .q(rx_data));
    dff #(.W(1),      .RESET_VALUE(1'b0))       u_valid (.clk(pclk), .rst_n(presetn), .d(valid_d), .q(rx_valid));
    dff #(.W(1),      .RESET_VALUE(1'b0))       u_ovr   (.clk(pclk), .rst_n(presetn), .d(ovr_d),   .q(rx_overrun));
endmodule

// File: doc/miso_rx.md
Name: miso_rx

Overview:
- Receive path of the SPI master. It is the counterpart of the MOSI generator.
- Samples `miso_pad_i` on each SCLK sampling strobe from the clock generator and assembles a 1–8 bit character, MSB-first or LSB-first.
- Transfers the completed character into a holding register with a valid/overrun handshake toward the APB register block.

Parameters:
- `DATA_W`, 8, character/holding register width. Only 8 is supported; the `char_len` encoding depends on it.
- `RESET_DATA`, 8'h00, reset value of the shift and holding registers.

Ports:
- `pclk`  in  1  system clock; all flops on rising edge.
- `presetn`  in  1  asynchronous active-low reset.
- `lsb`  in  1  1 = first received bit is bit 0; 0 = first received bit is bit N-1.
- `char_len`  in  3  character length N; 3'b000 = 8 bits, otherwise N = `char_len` (1..7).
- `transfer_start`  in  1  single-cycle pulse; begins a character.
- `transfer_abort`  in  1  discards the partial character; returns to IDLE.
- `sample_en`  in  1  single-cycle strobe at each SCLK sampling edge.
- `miso_pad_i`  in  1  serial data from slave, synchronous to `pclk` domain.
- `rx_read`  in  1  pulse from register block; acknowledges `rx_data`.
- `rx_data`  out  8  holding register; bits [7:N] always 0.
- `rx_valid`  out  1  `rx_data` holds an unread character.
- `rx_overrun`  out  1  sticky; a character was loaded while `rx_valid` = 1.
- `busy`  out  1  high in SHIFT and LOAD.

Behaviour:
- Reset (async, presetn = 0):
  - state = IDLE, bit counter = 0, shift register = `RESET_DATA`.
  - `rx_data` = `RESET_DATA`, `rx_valid` = 0, `rx_overrun` = 0, `busy` = 0.
- Reset mid-character discards all progress; no `rx_valid` is produced.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - `transfer_start` → SHIFT; shift register cleared to 0, counter cleared to 0.
  - `sample_en` in IDLE is ignored.
- SHIFT:
  - On `sample_en`, the bit is written to `shreg[idx]`:
    - idx = cnt when `lsb` = 1;
    - idx = N-1-cnt when `lsb` = 0.
  - Then cnt increments (3-bit counter, compared against N-1; no wrap beyond N-1).
  - On the `sample_en` with cnt == N-1, the bit is written and the next state is LOAD.
  - `transfer_start` in SHIFT or LOAD is ignored.
- LOAD (exactly one cycle):
  - `rx_data` ← shift register; `rx_valid` ← 1.
  - If `rx_valid` was already 1 and `rx_read` is not asserted this cycle, `rx_overrun` ← 1. The old data is overwritten.
  - Next state is IDLE.
- Latency: last `sample_en` in cycle c → `rx_data`/`rx_valid` visible from cycle c+2.
- `rx_read` handling:
  - Clears `rx_valid` and `rx_overrun` on the next edge.
  - If `rx_read` coincides with LOAD, the load wins: `rx_valid` stays 1, `rx_overrun` is unchanged (0 if it was 0), and the new data is presented.
- `transfer_abort` has priority over `sample_en` and LOAD:
  - Any state → IDLE; counter cleared.
  - `rx_data`, `rx_valid` and `rx_overrun` are untouched.
  - Abort in the LOAD cycle suppresses the load.
- `lsb` and `char_len` are sampled continuously. Software must hold them stable while `busy` = 1; changing them mid-character is undefined.
- Bit ordering is consistent with the MOSI generator: MSB-first N-bit character is transmitted/received as bit N-1 first.

Decomposition:
- Shared package `spi_pkg`:
  - state enum `rx_state_e` {IDLE, SHIFT, LOAD};
  - function `char_bits(char_len)` returning N (4-bit, 8 for 3'b000);
  - localparam `SPI_DATA_W` = 8.
- The FSM, counter and shift register stay in `miso_rx`.
- All state flops use the codebase `dff` cell with explicit `RESET_VALUE`.
- No sub-module beyond `dff` instances.

Test Plan:
1. presetn low mid-SHIFT (after 3 samples) → all outputs 0 immediately; subsequent `transfer_start` + 8 samples of 0xA5 MSB-first → `rx_data` = 8'hA5.
2. `char_len` = 0, `lsb` = 0, `miso` bits 1,0,1,1,0,0,1,0 → `rx_data` = 8'hB2, `rx_valid` rising exactly 2 cycles after 8th `sample_en`, `busy` low thereafter.
3. `char_len` = 3'b101, `lsb` = 1, bits 1,1,0,0,1 → `rx_data` = 8'h13, bits [7:5] = 0.
4. Two characters 0x11 then 0x22 with no `rx_read` → `rx_data` = 8'h22, `rx_overrun` = 1. `rx_read` → both flags 0. Repeat with `rx_read` in the LOAD cycle of the 2nd character → `rx_valid` = 1, `rx_overrun` = 0.
5. `transfer_abort` after 4 of 8 samples, previous `rx_data` = 8'h5A valid → `rx_data` still 8'h5A, `rx_valid` = 1, `busy` = 0. Extra `sample_en` pulses in IDLE → no change.
6. `transfer_start` pulsed again during SHIFT → ignored; character completes with correct data and bit count.
